// File: rtl/volume_pkg.sv
// rtl/volume_pkg.sv - shared state enum, level constants and width helper for the volume button front end
// Contents:
//   state_t      controller FSM states
//   LEVEL_MIN    lowest attenuator shift (shared with the attenuator)
//   LEVEL_MAX    highest attenuator shift
//   LEVEL_RESET  shift after reset
//   level_width  bits needed to hold a level up to max_level
package volume_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PRESS,
        DELAY,
        REPEAT,
        HELD,
        LOCK
    } state_t;

    localparam int LEVEL_MIN   = 1;
    localparam int LEVEL_MAX   = 7;
    localparam int LEVEL_RESET = 3;

    function automatic int level_width(input int max_level);
        return $clog2(max_level + 1);
    endfunction

endpackage

// File: rtl/volume_button_ctrl_button_debounce.sv
// rtl/volume_button_ctrl_button_debounce.sv - two-flop synchroniser plus debounce counter for one button
// Ports:
//   clk_i      in   system clock
//   reset_i    in   synchronous active-high reset
//   btn_i      in   raw asynchronous button, active-high
//   level_o    out  debounced button state
//   press_o    out  one-cycle strobe when level_o rises
//   release_o  out  one-cycle strobe when level_o falls
module button_debounce #(
    parameter int debounce_cycles_p = 4
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic btn_i,
    output logic level_o,
    output logic press_o,
    output logic release_o
);

    localparam int CW = (debounce_cycles_p > 1) ? $clog2(debounce_cycles_p) : 1;

    logic [1:0]    sync;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            sync      <= '0;
            cnt       <= '0;
            level_o   <= 1'b0;
            press_o   <= 1'b0;
            release_o <= 1'b0;
        end else begin
            sync      <= {sync[0], btn_i};
            press_o   <= 1'b0;
            release_o <= 1'b0;
            // Count consecutive samples that disagree with the accepted state;
            // any agreeing sample throws the partial count away.
            if (sync[1] != level_o) begin
                if (cnt == CW'(debounce_cycles_p - 1)) begin
                    level_o   <= sync[1];
                    press_o   <= sync[1];
                    release_o <= ~sync[1];
                    cnt       <= '0;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/volume_button_ctrl.sv
// rtl/volume_button_ctrl.sv - turns up/down push-buttons into saturating single-cycle volume step pulses
// Build option: VOLUME_AUTO_REPEAT_EN enables auto-repeat (DELAY/REPEAT states) while a button is held.
// Ports:
//   clk_i       in   system clock
//   reset_i     in   synchronous active-high reset
//   up_btn_i    in   raw up button, asynchronous, active-high
//   down_btn_i  in   raw down button, asynchronous, active-high
//   up_o        out  one-cycle pulse, level +1 (to attenuator up_i)
//   down_o      out  one-cycle pulse, level -1 (to attenuator down_i)
//   level_o     out  current level, saturating in [level_min_p, level_max_p]
module volume_button_ctrl
    import volume_pkg::*;
#(
    parameter int debounce_cycles_p = 4,
    parameter int repeat_delay_p    = 16,
    parameter int repeat_rate_p     = 8,
    parameter int level_min_p       = LEVEL_MIN,
    parameter int level_max_p       = LEVEL_MAX,
    parameter int level_reset_p     = LEVEL_RESET
) (
    input  logic                                 clk_i,
    input  logic                                 reset_i,
    input  logic                                 up_btn_i,
    input  logic                                 down_btn_i,
    output logic                                 up_o,
    output logic                                 down_o,
    output logic [level_width(level_max_p)-1:0]  level_o
);

    localparam int LW = level_width(level_max_p);

    logic   up_lvl, up_press, up_rel;
    logic   down_lvl, down_press, down_rel;
    logic   active_up;
    logic   can_up, can_down;
    state_t state;

    button_debounce #(.debounce_cycles_p(debounce_cycles_p)) u_up_db (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .btn_i     (up_btn_i),
        .level_o   (up_lvl),
        .press_o   (up_press),
        .release_o (up_rel)
    );

    button_debounce #(.debounce_cycles_p(debounce_cycles_p)) u_down_db (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .btn_i     (down_btn_i),
        .level_o   (down_lvl),
        .press_o   (down_press),
        .release_o (down_rel)
    );

    // Saturation check; a pulse still in flight has not reached level_o yet,
    // so no new pulse is allowed in the cycle right after one.
    assign can_up   = (level_o < LW'(level_max_p)) && !up_o && !down_o;
    assign can_down = (level_o > LW'(level_min_p)) && !up_o && !down_o;

`ifdef VOLUME_AUTO_REPEAT_EN
    localparam int RPT_MAX = (repeat_delay_p > repeat_rate_p) ? repeat_delay_p : repeat_rate_p;
    localparam int RW      = $clog2(RPT_MAX + 1);

    // Cycles since the last pulse attempt; cleared on every attempt.
    logic [RW-1:0] rpt_cnt;
`else
    localparam int unused_repeat_cfg = repeat_delay_p + repeat_rate_p;
`endif

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state     <= IDLE;
            active_up <= 1'b0;
            up_o      <= 1'b0;
            down_o    <= 1'b0;
            level_o   <= LW'(level_reset_p);
`ifdef VOLUME_AUTO_REPEAT_EN
            rpt_cnt   <= '0;
`endif
        end else begin
            up_o   <= 1'b0;
            down_o <= 1'b0;
            if (up_o) begin
                level_o <= level_o + LW'(1);
            end else if (down_o) begin
                level_o <= level_o - LW'(1);
            end

            case (state)
                IDLE: begin
                    if (up_lvl && down_lvl) begin
                        state <= LOCK;
                    end else if (up_press) begin
                        state     <= PRESS;
                        active_up <= 1'b1;
                        up_o      <= can_up;
`ifdef VOLUME_AUTO_REPEAT_EN
                        rpt_cnt   <= '0;
`endif
                    end else if (down_press) begin
                        state     <= PRESS;
                        active_up <= 1'b0;
                        down_o    <= can_down;
`ifdef VOLUME_AUTO_REPEAT_EN
                        rpt_cnt   <= '0;
`endif
                    end
                end

                PRESS, DELAY, REPEAT, HELD: begin
                    if (up_lvl && down_lvl) begin
                        state <= LOCK;
                    end else if (active_up ? up_rel : down_rel) begin
                        state <= IDLE;
                    end else begin
`ifdef VOLUME_AUTO_REPEAT_EN
                        if (state == PRESS) begin
                            state   <= DELAY;
                            rpt_cnt <= rpt_cnt + RW'(1);
                        end else if ((state == DELAY  && rpt_cnt == RW'(repeat_delay_p - 1)) ||
                                     (state == REPEAT && rpt_cnt == RW'(repeat_rate_p - 1))) begin
                            state   <= REPEAT;
                            rpt_cnt <= '0;
                            up_o    <= active_up && can_up;
                            down_o  <= !active_up && can_down;
                        end else begin
                            rpt_cnt <= rpt_cnt + RW'(1);
                        end
`else
                        state <= HELD;
`endif
                    end
                end

                LOCK: begin
                    if (!up_lvl && !down_lvl) begin
                        state <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
